// File: rtl/div_arbiter.sv
// div_arbiter: round-robin owner of a shared sequential divider.
// Grants one of two requesters, steers the operand mux, pulses the divider
// start, waits for a fresh valid rising edge and returns a one-cycle done.
// Optional feature macro: DIV_TIMEOUT_EN adds a WAIT watchdog that aborts
// with done+err after TIMEOUT WAIT cycles; without it err is tied low.
module div_arbiter #(
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       div_valid,
  output logic [1:0] gnt,
  output logic       src_sel,
  output logic       div_start,
  output logic [1:0] done,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   vprev;
  logic   win;
  logic   valid_edge;

  // A valid level left over from an earlier operation is not an edge.
  assign valid_edge = div_valid & ~vprev;

  // Single request wins outright; on a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             expired;

  // cnt counts WAIT cycles already spent; this is the last permitted one.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif

  // Arbiter FSM; every output is a register loaded together with the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      vprev     <= 1'b0;
      gnt       <= 2'b00;
      src_sel   <= 1'b0;
      div_start <= 1'b0;
      done      <= 2'b00;
      busy      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      err       <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      done      <= 2'b00;
      vprev     <= div_valid;
`ifdef DIV_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state     <= START;
            owner     <= win;
            gnt       <= win ? 2'b10 : 2'b01;
            src_sel   <= win;
            div_start <= 1'b1;
            busy      <= 1'b1;
            vprev     <= 1'b0;
          end
        end
        START: begin
          state <= WAIT;
`ifdef DIV_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (valid_edge) begin
            state <= DONE;
            done  <= owner ? 2'b10 : 2'b01;
          end
`ifdef DIV_TIMEOUT_EN
          else if (expired) begin
            state <= DONE;
            done  <= owner ? 2'b10 : 2'b01;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          last  <= owner;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a per-cycle vector table plus hand-written
// sequences for divider latency, strict alternation, asynchronous reset during
// WAIT and (when DIV_TIMEOUT_EN is defined) the WAIT watchdog.
module tb_div_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic       div_valid;
  logic [1:0] gnt;
  logic       src_sel;
  logic       div_start;
  logic [1:0] done;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  div_arbiter #(.TIMEOUT(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .div_valid (div_valid),
    .gnt       (gnt),
    .src_sel   (src_sel),
    .div_start (div_start),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] req;
    logic       dv;
    logic [1:0] gnt;
    logic       sel;
    logic       start;
    logic [1:0] done;
    logic       busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs of the new cycle are stable.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = 2'b00;
    div_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outputs", {8'h0, gnt, src_sel, div_start, done, err, busy}, 16'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int dcyc;
    int found;
    logic [1:0] eg;

    //                 req    dv    gnt    sel   start done   busy
    vec[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vec[1]  = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[2]  = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[3]  = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1};
    vec[4]  = '{2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vec[5]  = '{2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1};
    vec[6]  = '{2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[7]  = '{2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[8]  = '{2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[9]  = '{2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[10] = '{2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1};
    vec[11] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
    vec[12] = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[13] = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[14] = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1};
    vec[15] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    vec[16] = '{2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1};
    vec[17] = '{2'b01, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[18] = '{2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1};
    vec[19] = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1};
    vec[20] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
    vec[21] = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    vec[22] = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[23] = '{2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
    vec[24] = '{2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1};
    vec[25] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};

    reset     = 1'b1;
    req       = 2'b00;
    div_valid = 1'b0;

    // Vector table: stale valid, dropped request, back-to-back, tie-breaking.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      cyc();
      req       = vec[i].req;
      div_valid = vec[i].dv;
      check($sformatf("vec%0d", i),
            {8'h0, gnt, src_sel, div_start, done, err, busy},
            {8'h0, vec[i].gnt, vec[i].sel, vec[i].start, vec[i].done, 1'b0, vec[i].busy});
    end

    // Divider model: valid rises 17 cycles after the start cycle.
    do_reset();
    cyc();
    req = 2'b01;
    cyc();
    req = 2'b00;
    check("lat_start", {12'h0, gnt, div_start, busy}, {12'h0, 2'b01, 1'b1, 1'b1});
    dcyc = -1;
    for (int c = 2; c < 40; c++) begin
      cyc();
      div_valid = (c >= 18);
      if (done != 2'b00) begin
        dcyc = c;
        check("lat_done_val", {14'h0, done}, 16'h1);
        check("lat_err", {15'h0, err}, 16'h0);
        break;
      end
    end
    check("lat_done_cycle", 16'(dcyc), 16'd19);

    // Both requesting continuously: grants alternate 0,1,0,1.
    do_reset();
    cyc();
    req = 2'b11;
    for (int op = 0; op < 4; op++) begin
      found = 0;
      for (int n = 0; n < 10; n++) begin
        cyc();
        div_valid = 1'b0;
        if (div_start) begin
          found = 1;
          break;
        end
      end
      eg = (op % 2 == 1) ? 2'b10 : 2'b01;
      check($sformatf("alt%0d_found", op), 16'(found), 16'd1);
      check($sformatf("alt%0d_gnt", op), {13'h0, gnt, src_sel}, {13'h0, eg, eg[1]});
      cyc();
      div_valid = 1'b1;
      check($sformatf("alt%0d_sel", op), {13'h0, gnt, src_sel}, {13'h0, eg, eg[1]});
      cyc();
      div_valid = 1'b0;
      check($sformatf("alt%0d_done", op), {14'h0, done}, {14'h0, eg});
    end

    // Asynchronous reset in WAIT: outputs drop at once, no done follows.
    do_reset();
    cyc();
    req = 2'b10;
    cyc();
    req = 2'b00;
    cyc();
    check("rst_in_wait", {13'h0, gnt, busy}, {13'h0, 2'b10, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", {13'h0, gnt, busy}, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    found = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      div_valid = (n % 2 == 1);
      if (done != 2'b00) found = 1;
    end
    check("rst_no_done", 16'(found), 16'd0);
    div_valid = 1'b0;
    cyc();
    req = 2'b11;
    cyc();
    req = 2'b00;
    check("rst_regrant", {13'h0, gnt, div_start}, {13'h0, 2'b01, 1'b1});

`ifdef DIV_TIMEOUT_EN
    // Valid never arrives: abort with done+err after 20 WAIT cycles.
    do_reset();
    cyc();
    req = 2'b01;
    cyc();
    req = 2'b00;
    dcyc = -1;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (done != 2'b00) begin
        dcyc = n;
        check("to_done_err", {13'h0, done, err}, {13'h0, 2'b01, 1'b1});
        break;
      end
    end
    check("to_wait_cycles", 16'(dcyc), 16'd20);
    cyc();
    check("to_idle", {13'h0, gnt, busy}, 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
